red_add_seq: RTL

- Multi-cycle sequencer that owns a single shared 8-bit carry-lookahead adder in the Execute stage.
- Computes either a 16-bit ADD (two passes) or a byte-reduction RED (three passes) by steering operand bytes and carries through that one adder.
- Sits beside the ALU. The pipeline control issues `start` and stalls on `busy` until `done` pulses.

---
 rtl/red_add_seq_pkg.sv | 18 +
 rtl/add8_cla.sv | 46 ++++
 rtl/red_add_seq.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/red_add_seq_pkg.sv
// Shared types and constants for the red_add_seq sequencer and its adder.
package red_add_seq_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned RED_W  = 10;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LO   = 3'd1,
        ST_HI   = 3'd2,
        ST_FIN  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam logic MODE_RED = 1'b0;
    localparam logic MODE_ADD = 1'b1;

endpackage

// File: rtl/add8_cla.sv
// 8-bit carry-lookahead adder built from two 4-bit lookahead groups.
module add8_cla
    import red_add_seq_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] s,
    output logic              cout
);

    // Carries into bits 1..3 of a nibble, fully expanded from the nibble carry-in.
    function automatic logic [2:0] inner_carry(input logic [3:0] g, input logic [3:0] p,
                                               input logic ci);
        logic [2:0] c;
        c[0] = g[0] | (p[0] & ci);
        c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        return c;
    endfunction

    logic [BYTE_W-1:0] g;
    logic [BYTE_W-1:0] p;
    logic [1:0]        grp_g;
    logic [1:0]        grp_p;
    logic              c4;
    logic [3:0]        c_lo;
    logic [3:0]        c_hi;

    assign g = a & b;
    assign p = a ^ b;

    assign grp_g[0] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign grp_g[1] = g[7] | (p[7] & g[6]) | (p[7] & p[6] & g[5]) | (p[7] & p[6] & p[5] & g[4]);
    assign grp_p[0] = &p[3:0];
    assign grp_p[1] = &p[7:4];

    assign c4   = grp_g[0] | (grp_p[0] & cin);
    assign cout = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & cin);

    assign c_lo = {inner_carry(g[3:0], p[3:0], cin), cin};
    assign c_hi = {inner_carry(g[7:4], p[7:4], c4), c4};

    assign s = p ^ {c_hi, c_lo};

endmodule

// File: rtl/red_add_seq.sv
// Sequencer steering a 16-bit ADD (two passes) or a four-byte sum RED (three passes)
// through one shared 8-bit carry-lookahead adder.
module red_add_seq
    import red_add_seq_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         mode,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         flush,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         cout
);

    state_e            state_q, state_d;
    logic [W-1:0]      a_q, a_d, b_q, b_d;
    logic              mode_q, mode_d;
    logic [BYTE_W:0]   lo9_q, lo9_d, hi9_q, hi9_d;
    logic [W-1:0]      result_q, result_d;
    logic              cout_q, cout_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [BYTE_W-1:0] add_a, add_b, add_s;
    logic              add_ci, add_co;
    logic [1:0]        red_top;

    // Operand steering: adder inputs come only from registered state.
    always_comb begin
        add_a  = '0;
        add_b  = '0;
        add_ci = 1'b0;
        case (state_q)
            ST_LO: begin
                add_a = a_q[BYTE_W-1:0];
                add_b = b_q[BYTE_W-1:0];
            end
            ST_HI: begin
                add_a  = a_q[2*BYTE_W-1:BYTE_W];
                add_b  = b_q[2*BYTE_W-1:BYTE_W];
                add_ci = (mode_q == MODE_ADD) ? lo9_q[BYTE_W] : 1'b0;
            end
            ST_FIN: begin
                add_a = lo9_q[BYTE_W-1:0];
                add_b = hi9_q[BYTE_W-1:0];
            end
            default: ;
        endcase
    end

    add8_cla u_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_ci),
        .s    (add_s),
        .cout (add_co)
    );

    assign red_top = 2'(lo9_q[BYTE_W]) + 2'(hi9_q[BYTE_W]) + 2'(add_co);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        mode_d   = mode_q;
        lo9_d    = lo9_q;
        hi9_d    = hi9_q;
        result_d = result_q;
        cout_d   = cout_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_d     = a;
                        b_d     = b;
                        mode_d  = mode;
                        state_d = ST_LO;
                    end
                end
                ST_LO: begin
                    lo9_d   = {add_co, add_s};
                    state_d = ST_HI;
                end
                ST_HI: begin
                    hi9_d = {add_co, add_s};
                    if (mode_q == MODE_ADD) begin
                        result_d = {add_s, lo9_q[BYTE_W-1:0]};
                        cout_d   = add_co;
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_FIN;
                    end
                end
                ST_FIN: begin
                    result_d = W'({red_top, add_s});
                    cout_d   = 1'b0;
                    state_d  = ST_DONE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= MODE_RED;
            lo9_q    <= '0;
            hi9_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mode_q   <= mode_d;
            lo9_q    <= lo9_d;
            hi9_q    <= hi9_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;

endmodule
